lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit LFSR pattern generator: consumes the serial pseudo-random bit stream and self-synchronises to it.
- Declares lock after a run of correctly predicted bits, then counts bit errors against a free-running local copy of the sequence.
- Sits at the sink end of any link or datapath driven by the generator; used for built-in self-test and for verifying generator output in hardware.

Parameters:
- LOCK_CNT, 16, consecutive correct predictions in HUNT required to assert locked (1..255).
- UNLOCK_CNT, 4, consecutive mispredictions in LOCKED that drop lock (1..255).
- CNT_W, 16, width of err_count and bit_count (2..32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- bit_in  input  1  received stream bit, sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for one cycle.
- clear  input  1  synchronous; zeroes err_count and bit_count only (state and lock unaffected).
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mispredicted bit in LOCKED.
- err_count  output  CNT_W  saturating count of bits mispredicted while LOCKED.
- bit_count  output  CNT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Shift register: 8-bit state s. Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form. Predicted bit p = s[7]^s[5]^s[4]^s[3]. Every shift is s <= {s[6:0], new_bit}.
- Reset (reset=0, async): state=SEED, s=0, fill/match/miss counters=0, locked=0, err_pulse=0, err_count=0, bit_count=0. Reset mid-operation aborts everything immediately.
- All outputs registered; an accepted bit affects outputs on the next rising edge. Cycles with bit_valid=0 change nothing except clear.
- SEED:
  - Each valid bit shifts bit_in into s and increments fill_cnt.
  - On the 8th bit: go to HUNT, match_cnt=0.
- HUNT:
  - s always shifts in bit_in (self-synchronising).
  - Match (bit_in==p and s!=0): match_cnt++.
  - Mismatch, or s==0 (all-zero guard; the all-zero state never counts toward lock): match_cnt=0.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, locked=1, miss_run=0.
- LOCKED:
  - s shifts in p, not bit_in (free-run), so received errors do not corrupt prediction.
  - Each valid bit: bit_count++ (saturating).
  - Mismatch: err_pulse=1 for one cycle, err_count++ (saturating at 2^CNT_W-1), miss_run++.
  - Match: miss_run=0.
  - When miss_run reaches UNLOCK_CNT: go to SEED, fill_cnt=0, locked=0 on the same edge that registers the final err_pulse.
- Lock latency from reset with a clean stream: 8 + LOCK_CNT valid bits; locked rises on the edge after that bit.
- clear with a simultaneous erroring bit: clear wins (counts = 0 that edge; err_pulse still asserts).
- Counters never wrap. err_count and bit_count hold across lock loss and relock, until clear or reset.
- No state is reachable other than SEED/HUNT/LOCKED; any illegal encoding recovers to SEED.

Test Plan:
- Reset, then clean stream from a generator model seeded 0x01, one bit per cycle: locked=0 through the 23rd bit; locked=1 after the 24th; err_count=0; bit_count=N-24 after N bits.
- Locked, flip a single bit: err_pulse high exactly 1 cycle; err_count=1; locked stays 1; following clean bits produce no further pulses.
- Locked, flip 4 consecutive bits: err_count=4, 4 pulses, locked falls with the 4th. Resume clean stream: relock after a further 24 bits, err_count still 4.
- 100 valid bits of constant 0 after reset: locked never asserts; err_count=0.
- Bench with CNT_W=4, lock, then invert alternating bits so miss_run never reaches 4: err_count saturates at 15. Pulse clear: both counters 0, locked unchanged.
- Locked, assert reset mid-stream with bit_valid gaps: all outputs 0 without a clock edge; after release, lock latency is again 24 valid bits regardless of gaps.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the x^8+x^6+x^5+x^4+1 LFSR pattern stream.
// Self-synchronises on the incoming bits, then free-runs its own copy of the
// sequence and counts mispredicted bits while locked.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned RUN_W = 8;
    localparam int unsigned FILL_W = 3;
    localparam logic [RUN_W-1:0]  MATCH_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0]  MISS_LAST  = RUN_W'(UNLOCK_CNT - 1);
    localparam logic [FILL_W-1:0] FILL_LAST  = FILL_W'(7);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        s, s_nxt;
    logic [FILL_W-1:0] fill_cnt, fill_nxt;
    logic [RUN_W-1:0]  match_cnt, match_nxt;
    logic [RUN_W-1:0]  miss_run, miss_nxt;
    logic              locked_nxt;
    logic              pulse_nxt;
    logic [CNT_W-1:0]  err_nxt, bits_nxt;
    logic              pred;

    // Next bit the local sequence expects
    assign pred = s[7] ^ s[5] ^ s[4] ^ s[3];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SEED;
        else        state <= state_nxt;
    end

    // Next-state, shift register, run counters and output values
    always_comb begin
        state_nxt  = state;
        s_nxt      = s;
        fill_nxt   = fill_cnt;
        match_nxt  = match_cnt;
        miss_nxt   = miss_run;
        locked_nxt = locked;
        pulse_nxt  = 1'b0;
        err_nxt    = err_count;
        bits_nxt   = bit_count;

        case (state)
            SEED: begin
                if (bit_valid) begin
                    s_nxt = {s[6:0], bit_in};
                    if (fill_cnt == FILL_LAST) begin
                        state_nxt = HUNT;
                        fill_nxt  = '0;
                        match_nxt = '0;
                    end else begin
                        fill_nxt = fill_cnt + FILL_W'(1);
                    end
                end
            end
            HUNT: begin
                if (bit_valid) begin
                    s_nxt = {s[6:0], bit_in};
                    // the all-zero state is self-consistent but never counts toward lock
                    if ((bit_in == pred) && (s != 8'd0)) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_nxt  = LOCKED;
                            locked_nxt = 1'b1;
                            match_nxt  = '0;
                            miss_nxt   = '0;
                        end else begin
                            match_nxt = match_cnt + RUN_W'(1);
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (bit_valid) begin
                    // free-run on the prediction so received errors do not corrupt it
                    s_nxt = {s[6:0], pred};
                    if (bit_count != CNT_MAX) bits_nxt = bit_count + CNT_W'(1);
                    if (bit_in != pred) begin
                        pulse_nxt = 1'b1;
                        if (err_count != CNT_MAX) err_nxt = err_count + CNT_W'(1);
                        if (miss_run == MISS_LAST) begin
                            state_nxt  = SEED;
                            fill_nxt   = '0;
                            locked_nxt = 1'b0;
                            miss_nxt   = '0;
                        end else begin
                            miss_nxt = miss_run + RUN_W'(1);
                        end
                    end else begin
                        miss_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt  = SEED;
                fill_nxt   = '0;
                match_nxt  = '0;
                miss_nxt   = '0;
                locked_nxt = 1'b0;
            end
        endcase

        // clear overrides any same-cycle increment
        if (clear) begin
            err_nxt  = '0;
            bits_nxt = '0;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            s         <= s_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            miss_run  <= miss_nxt;
            locked    <= locked_nxt;
            err_pulse <= pulse_nxt;
            err_count <= err_nxt;
            bit_count <= bits_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed, table-driven bench for lfsr_checker. A reference generator
// (seed 0x01) supplies the stream; each table row is a segment of bits with
// an optional corruption pattern and the expected outputs at its end.
module tb_lfsr_checker;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W4 = 4;
    localparam int M_CLEAN = 0;
    localparam int M_FLIP  = 1;
    localparam int M_ZERO  = 2;
    localparam int M_ALT   = 3;
    localparam int NSEG    = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic clear = 1'b0;

    logic              locked, err_pulse;
    logic [CNT_W-1:0]  err_count, bit_count;
    logic              locked4, err_pulse4;
    logic [CNT_W4-1:0] err_count4, bit_count4;

    lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    lfsr_checker #(.LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(CNT_W4)) dut4 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nbits;
        int mode;
        bit gaps;
        bit clr;
        bit rst;
        bit exp_locked;
        int exp_pulses;
        int exp_err;
        int exp_bits;
        int exp_lock_cyc;   // -1: not checked
        bit chk4;
        int exp_err4;
        int exp_bits4;
    } seg_t;

    seg_t tbl [NSEG];
    logic [7:0] gen = 8'h01;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lock_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic gen_bit(output logic b);
        b = gen[7] ^ gen[5] ^ gen[4] ^ gen[3];
        gen = {gen[6:0], b};
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge
    task automatic cycle(input logic v, input logic b, input logic c);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        @(posedge clk);
        #1;
        if (err_pulse) pulses++;
        if (locked) lock_cyc++;
    endtask

    // Asynchronous reset between clock edges; outputs must clear with no edge
    task automatic do_reset(input int k);
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
        #1;
        check($sformatf("seg%0d rst locked", k), int'(locked), 0);
        check($sformatf("seg%0d rst err_pulse", k), int'(err_pulse), 0);
        check($sformatf("seg%0d rst err_count", k), int'(err_count), 0);
        check($sformatf("seg%0d rst bit_count", k), int'(bit_count), 0);
        check($sformatf("seg%0d rst locked4", k), int'(locked4), 0);
        check($sformatf("seg%0d rst err_pulse4", k), int'(err_pulse4), 0);
        check($sformatf("seg%0d rst bit_count4", k), int'(bit_count4), 0);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        //            nbits mode     gap clr rst  lk pul err bits lcyc c4 e4 b4
        // clean lock: 23 bits not locked, 24th locks, then counting
        tbl[0]  = '{23, M_CLEAN, 0, 0, 1,  0, 0,  0,  0,  0, 0, 0, 0};
        tbl[1]  = '{ 1, M_CLEAN, 0, 0, 0,  1, 0,  0,  0, -1, 0, 0, 0};
        tbl[2]  = '{10, M_CLEAN, 0, 0, 0,  1, 0,  0, 10, -1, 0, 0, 0};
        // single flipped bit, then clean
        tbl[3]  = '{ 1, M_FLIP,  0, 0, 0,  1, 1,  1, 11, -1, 0, 0, 0};
        tbl[4]  = '{ 5, M_CLEAN, 0, 0, 0,  1, 0,  1, 16, -1, 0, 0, 0};
        // idle clear cycle
        tbl[5]  = '{ 0, M_CLEAN, 0, 1, 0,  1, 0,  0,  0, -1, 0, 0, 0};
        // four consecutive flips: lock drops with the 4th pulse
        tbl[6]  = '{ 3, M_FLIP,  0, 0, 0,  1, 3,  3,  3, -1, 0, 0, 0};
        tbl[7]  = '{ 1, M_FLIP,  0, 0, 0,  0, 1,  4,  4, -1, 0, 0, 0};
        // relock after another 24 bits, counts held
        tbl[8]  = '{23, M_CLEAN, 0, 0, 0,  0, 0,  4,  4,  0, 0, 0, 0};
        tbl[9]  = '{ 1, M_CLEAN, 0, 0, 0,  1, 0,  4,  4, -1, 0, 0, 0};
        tbl[10] = '{ 6, M_CLEAN, 0, 0, 0,  1, 0,  4, 10, -1, 0, 0, 0};
        // clear with a simultaneous error: counts zero, pulse still fires
        tbl[11] = '{ 1, M_FLIP,  0, 1, 0,  1, 1,  0,  0, -1, 0, 0, 0};
        // all-zero stream never locks
        tbl[12] = '{100, M_ZERO, 0, 0, 1,  0, 0,  0,  0,  0, 0, 0, 0};
        // saturation on the 4-bit instance with alternating errors
        tbl[13] = '{24, M_CLEAN, 0, 0, 1,  1, 0,  0,  0, -1, 1, 0, 0};
        tbl[14] = '{40, M_ALT,   0, 0, 0,  1, 20, 20, 40, -1, 1, 15, 15};
        tbl[15] = '{ 0, M_CLEAN, 0, 1, 0,  1, 0,  0,  0, -1, 1, 0, 0};
        // gapped traffic, end on an error pulse, then reset mid-stream
        tbl[16] = '{ 5, M_CLEAN, 1, 0, 0,  1, 0,  0,  5, -1, 1, 0, 5};
        tbl[17] = '{ 1, M_FLIP,  1, 0, 0,  1, 1,  1,  6, -1, 1, 1, 6};
        tbl[18] = '{23, M_CLEAN, 1, 0, 1,  0, 0,  0,  0,  0, 1, 0, 0};
        tbl[19] = '{ 1, M_CLEAN, 1, 0, 0,  1, 0,  0,  0, -1, 1, 0, 0};

        for (int k = 0; k < NSEG; k++) begin
            seg_t t;
            logic gb;
            t = tbl[k];
            if (t.rst) do_reset(k);
            pulses   = 0;
            lock_cyc = 0;
            if (t.nbits == 0) cycle(1'b0, 1'b0, t.clr);
            for (int i = 0; i < t.nbits; i++) begin
                if (t.gaps) begin
                    for (int g = 0; g < i % 3; g++) cycle(1'b0, 1'b0, t.clr);
                end
                gb = 1'b0;
                if (t.mode != M_ZERO) gen_bit(gb);
                if (t.mode == M_FLIP) gb = ~gb;
                if (t.mode == M_ALT && (i % 2 == 0)) gb = ~gb;
                cycle(1'b1, gb, t.clr);
            end
            check($sformatf("seg%0d locked", k), int'(locked), int'(t.exp_locked));
            check($sformatf("seg%0d pulses", k), pulses, t.exp_pulses);
            check($sformatf("seg%0d err_count", k), int'(err_count), t.exp_err);
            check($sformatf("seg%0d bit_count", k), int'(bit_count), t.exp_bits);
            if (t.exp_lock_cyc >= 0)
                check($sformatf("seg%0d locked_cycles", k), lock_cyc, t.exp_lock_cyc);
            if (t.chk4) begin
                check($sformatf("seg%0d locked4", k), int'(locked4), int'(t.exp_locked));
                check($sformatf("seg%0d err_count4", k), int'(err_count4), t.exp_err4);
                check($sformatf("seg%0d bit_count4", k), int'(bit_count4), t.exp_bits4);
            end
        end

        // pulse must not linger once the stream goes idle
        cycle(1'b0, 1'b0, 1'b0);
        check("idle err_pulse", int'(err_pulse), 0);
        check("idle locked", int'(locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
